// File: rtl/multiword_add_sequencer_pkg.sv
// rtl/multiword_add_sequencer_pkg.sv - shared types, sizing helpers and defaults for the multiword adder
package multiword_add_sequencer_pkg;

  // Sequencer phases: waiting for a job, stepping slices, holding the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_SLICE_WIDTH = 8;

  // Number of slice steps needed to cover the full operand
  function automatic int nslice(input int data_width, input int slice_width);
    return data_width / slice_width;
  endfunction

  // Slice counter width; a single-slice job still needs a 1-bit counter
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operands must split into whole slices
  function automatic bit width_ok(input int data_width, input int slice_width);
    return (slice_width >= 1) && (slice_width <= data_width) &&
           ((data_width % slice_width) == 0);
  endfunction

  localparam int DEFAULT_NSLICE = nslice(DEFAULT_DATA_WIDTH, DEFAULT_SLICE_WIDTH);

endpackage

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - narrow combinational adder slice with carry-out and carry into MSB
module ripple_carry_adder #(
  parameter int data_width = 8
) (
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic                  cin,
  output logic [data_width-1:0] sum,
  output logic                  cout,
  output logic                  carry_msb
);

  logic [data_width:0] total;

  // Full add of the slice; the extra top bit is the carry out
  always_comb begin
    total     = {1'b0, a} + {1'b0, b} + {{data_width{1'b0}}, cin};
    sum       = total[data_width-1:0];
    cout      = total[data_width];
    // The carry that entered the MSB is recovered from that bit's sum
    carry_msb = a[data_width-1] ^ b[data_width-1] ^ total[data_width-1];
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - wide add through one narrow slice per clock; MWADD_SUB_EN adds a subtract input
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SLICE_WIDTH = DEFAULT_SLICE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic                  cin,
`ifdef MWADD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int NSLICE = nslice(DATA_WIDTH, SLICE_WIDTH);
  localparam int CW     = cnt_width(NSLICE);

  if (!width_ok(DATA_WIDTH, SLICE_WIDTH)) begin : g_width_check
    $error("DATA_WIDTH must be a whole multiple of SLICE_WIDTH");
  end

  state_t                  state;
  logic [DATA_WIDTH-1:0]   x_reg;
  logic [DATA_WIDTH-1:0]   y_reg;
  logic                    carry;
  logic [CW-1:0]           cnt;

  logic [DATA_WIDTH-1:0]   eff_y;
  logic                    eff_cin;
  logic [SLICE_WIDTH-1:0]  slice_a;
  logic [SLICE_WIDTH-1:0]  slice_b;
  logic [SLICE_WIDTH-1:0]  slice_sum;
  logic                    slice_cout;
  logic                    slice_c_msb;
  logic                    last;

`ifdef MWADD_SUB_EN
  // Subtract is x + ~y + 1; cin is ignored in that mode
  assign eff_y   = sub ? ~y : y;
  assign eff_cin = sub ? 1'b1 : cin;
`else
  assign eff_y   = y;
  assign eff_cin = cin;
`endif

  assign last = (cnt == CW'(NSLICE - 1));

  // Select the operand slice addressed by the slice counter
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        slice_a = x_reg[k*SLICE_WIDTH +: SLICE_WIDTH];
        slice_b = y_reg[k*SLICE_WIDTH +: SLICE_WIDTH];
      end
    end
  end

  ripple_carry_adder #(
    .data_width(SLICE_WIDTH)
  ) u_slice_adder (
    .a        (slice_a),
    .b        (slice_b),
    .cin      (carry),
    .sum      (slice_sum),
    .cout     (slice_cout),
    .carry_msb(slice_c_msb)
  );

  // Job FSM: latch operands, step one slice per clock, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg    <= x;
            y_reg    <= eff_y;
            carry    <= eff_cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (cnt == CW'(k)) begin
              sum[k*SLICE_WIDTH +: SLICE_WIDTH] <= slice_sum;
            end
          end
          carry <= slice_cout;
          if (last) begin
            cout      <= slice_cout;
            ovf       <= slice_cout ^ slice_c_msb;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // in_ready rises only after the result handshake, so jobs never overlap
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - randomized self-checking bench for the multiword adder
module tb_multiword_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv0 = 1'b0;
  logic        iv1 = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        cin = 1'b0;
  logic        out_ready = 1'b0;
`ifdef MWADD_SUB_EN
  logic        sub = 1'b0;
`endif

  logic        ir0, ov0, co0, of0;
  logic [31:0] s0;
  logic        ir1, ov1, co1, of1;
  logic [31:0] s1;

  logic        sel = 1'b0;
  logic        m_ir, m_ov, m_co, m_of;
  logic [31:0] m_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.DATA_WIDTH(32), .SLICE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .x(x), .y(y), .cin(cin),
`ifdef MWADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(of0)
  );

  multiword_add_sequencer #(.DATA_WIDTH(32), .SLICE_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .x(x), .y(y), .cin(cin),
`ifdef MWADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1)
  );

  assign m_ir = sel ? ir1 : ir0;
  assign m_ov = sel ? ov1 : ov0;
  assign m_s  = sel ? s1  : s0;
  assign m_co = sel ? co1 : co0;
  assign m_of = sel ? of1 : of0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, sum}
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    longint ua, ub, us, sa, sb, sr;
    logic   co, ov;
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (s) begin
      us = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      us = ua + ub + longint'(c);
      co = (us >= 64'sd4294967296);
      sr = sa + sb + longint'(c);
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ov, co, us[31:0]};
  endfunction

  // One job: accept, time latency, check result, optionally stall in DONE, then consume
  task automatic run_job(input logic which, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s, input int hold, input int exp_lat);
    logic [33:0] e;
    int          lat;
    sel = which;
    #0;
    check_eq("in_ready_before_accept", 64'(m_ir), 64'd1);
    x = a; y = b; cin = c;
`ifdef MWADD_SUB_EN
    sub = s;
`endif
    if (which) iv1 = 1'b1; else iv0 = 1'b1;
    tick();
    iv0 = 1'b0; iv1 = 1'b0;
    x = $urandom; y = $urandom; cin = 1'($urandom);
    lat = 0;
    while (!m_ov && lat < 50) begin
      tick();
      lat++;
    end
    e = model(a, b, c, s);
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("sum", 64'(m_s), 64'(e[31:0]));
    check_eq("cout", 64'(m_co), 64'(e[32]));
    check_eq("ovf", 64'(m_of), 64'(e[33]));
    for (int i = 0; i < hold; i++) begin
      if (which) iv1 = ~iv1; else iv0 = ~iv0;
      x = $urandom; y = $urandom;
      tick();
      check_eq("hold_out_valid", 64'(m_ov), 64'd1);
      check_eq("hold_in_ready", 64'(m_ir), 64'd0);
      check_eq("hold_sum", 64'(m_s), 64'(e[31:0]));
    end
    iv0 = 1'b0; iv1 = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("consumed_out_valid", 64'(m_ov), 64'd0);
    check_eq("consumed_in_ready", 64'(m_ir), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_in_ready", 64'(ir0), 64'd1);
    check_eq("reset_out_valid", 64'(ov0), 64'd0);
    check_eq("reset_sum", 64'(s0), 64'd0);
    check_eq("reset_cout", 64'(co0), 64'd0);
    check_eq("reset_ovf", 64'(of0), 64'd0);

    run_job(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 4);
    run_job(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 4);
    run_job(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0, 4);
    check_eq("directed_sum_2345678a", 64'(s0), 64'h2345_678A);

    run_job(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 5, 4);
    run_job(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 4);

    // Abort in the second RUN cycle
    sel = 1'b0;
    x = 32'hFFFF_FFFF; y = 32'h0000_0001; cin = 1'b1;
    iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_out_valid", 64'(ov0), 64'd0);
    check_eq("abort_sum", 64'(s0), 64'd0);
    check_eq("abort_in_ready", 64'(ir0), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("abort_no_result", 64'(ov0), 64'd0);
    end
    run_job(1'b0, 32'd3, 32'd4, 1'b0, 1'b0, 0, 4);
    check_eq("after_abort_sum_7", 64'(s0), 64'd7);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = 32'h7FFF_FFFF;
        1: rb = ~ra;
        default: ;
      endcase
`ifdef MWADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_job(1'b0, ra, rb, 1'($urandom), rs, $urandom_range(0, 3), 4);
    end

    run_job(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      run_job(1'b1, $urandom, $urandom, 1'($urandom), 1'b0, $urandom_range(0, 2), 1);
    end

`ifdef MWADD_SUB_EN
    run_job(1'b0, 32'd5, 32'd7, 1'b0, 1'b1, 0, 4);
    check_eq("sub_5_7_sum", 64'(s0), 64'hFFFF_FFFE);
    run_job(1'b0, 32'd7, 32'd5, 1'b0, 1'b1, 0, 4);
    check_eq("sub_7_5_sum", 64'(s0), 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
